// File: rtl/mux_seq_pkg.sv
// Shared types and entry-packing constants for the mux sequencer.
// An entry is packed MSB->LSB as {sel_const, sel_fun, sel_acum, senal_en, hold}.
package mux_seq_pkg;

   localparam int DEF_N_STEPS = 16;
   localparam int DEF_CONST_W = 3;
   localparam int DEF_FUN_W   = 2;
   localparam int DEF_ACUM_W  = 2;
   localparam int DEF_HOLD_W  = 4;

   localparam int HOLD_LSB  = 0;
   localparam int SENAL_BIT = HOLD_LSB + DEF_HOLD_W;
   localparam int ACUM_LSB  = SENAL_BIT + 1;
   localparam int FUN_LSB   = ACUM_LSB + DEF_ACUM_W;
   localparam int CONST_LSB = FUN_LSB + DEF_FUN_W;
   localparam int ENTRY_W   = CONST_LSB + DEF_CONST_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic [DEF_CONST_W-1:0] sel_const;
      logic [DEF_FUN_W-1:0]   sel_fun;
      logic [DEF_ACUM_W-1:0]  sel_acum;
      logic                   senal_en;
      logic [DEF_HOLD_W-1:0]  hold;
   } entry_t;

   function automatic entry_t unpack_entry(input logic [ENTRY_W-1:0] raw);
      return entry_t'(raw);
   endfunction

   function automatic logic [ENTRY_W-1:0] pack_entry(
      input logic [DEF_CONST_W-1:0] sel_const,
      input logic [DEF_FUN_W-1:0]   sel_fun,
      input logic [DEF_ACUM_W-1:0]  sel_acum,
      input logic                   senal_en,
      input logic [DEF_HOLD_W-1:0]  hold
   );
      entry_t e;
      e.sel_const = sel_const;
      e.sel_fun   = sel_fun;
      e.sel_acum  = sel_acum;
      e.senal_en  = senal_en;
      e.hold      = hold;
      return e;
   endfunction

endpackage

// File: rtl/mux_seq_if.sv
// Control/config/select bundle between the controller (master) and the sequencer (slave).
interface mux_seq_if
   import mux_seq_pkg::*;
#(
   parameter int N_STEPS = DEF_N_STEPS,
   parameter int CONST_W = DEF_CONST_W,
   parameter int FUN_W   = DEF_FUN_W,
   parameter int ACUM_W  = DEF_ACUM_W,
   parameter int HOLD_W  = DEF_HOLD_W
);
   localparam int IDX_W = $clog2(N_STEPS);
   localparam int E_W   = CONST_W + FUN_W + ACUM_W + 1 + HOLD_W;

   logic               start;
   logic               abort;
   logic               loop_en;
   logic [IDX_W:0]     num_steps;
   logic               cfg_we;
   logic [IDX_W-1:0]   cfg_addr;
   logic [E_W-1:0]     cfg_data;
   logic [CONST_W-1:0] sel_const;
   logic [FUN_W-1:0]   sel_fun;
   logic [ACUM_W-1:0]  sel_acum;
   logic               senal;
   logic               busy;
   logic               ultimo;
   logic               band_listo;

   modport master (
      output start, abort, loop_en, num_steps, cfg_we, cfg_addr, cfg_data,
      input  sel_const, sel_fun, sel_acum, senal, busy, ultimo, band_listo
   );

   modport slave (
      input  start, abort, loop_en, num_steps, cfg_we, cfg_addr, cfg_data,
      output sel_const, sel_fun, sel_acum, senal, busy, ultimo, band_listo
   );

endinterface

// File: rtl/mux_seq_table.sv
// Step table: N_STEPS x E_W register file, one gated sync write port, one async read port.
module mux_seq_table #(
   parameter int N_STEPS = 16,
   parameter int E_W     = 12,
   localparam int IDX_W  = $clog2(N_STEPS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic             busy,
   input  logic [IDX_W-1:0] addr,
   input  logic [E_W-1:0]   wdata,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [E_W-1:0]   rd_data
);

   logic [E_W-1:0] mem [N_STEPS];
   logic           addr_ok;
   logic           wr_en;

   generate
      if (N_STEPS == (1 << IDX_W)) begin : g_full_range
         assign addr_ok = 1'b1;
      end else begin : g_partial_range
         assign addr_ok = (int'(addr) < N_STEPS);
      end
   endgenerate

   assign wr_en = we && !busy && addr_ok;

   // NOTE: the table is a plain register file, so it can take the async clear;
   // a RAM macro could not, and every entry would then need an explicit init pass.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_STEPS; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[addr] <= wdata;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/mux_sequencer.sv
// Table-driven mux-select sequencer: steps through programmed select words with
// per-step hold and strobe, in one-shot or continuous-loop mode.
module mux_sequencer
   import mux_seq_pkg::*;
#(
   parameter int N_STEPS = DEF_N_STEPS,
   parameter int CONST_W = DEF_CONST_W,
   parameter int FUN_W   = DEF_FUN_W,
   parameter int ACUM_W  = DEF_ACUM_W,
   parameter int HOLD_W  = DEF_HOLD_W
) (
   input logic    clk,
   input logic    reset,
   mux_seq_if.slave bus
);

   localparam int IDX_W = $clog2(N_STEPS);
   localparam int E_W   = CONST_W + FUN_W + ACUM_W + 1 + HOLD_W;

   localparam int O_HOLD  = 0;
   localparam int O_SENAL = O_HOLD + HOLD_W;
   localparam int O_ACUM  = O_SENAL + 1;
   localparam int O_FUN   = O_ACUM + ACUM_W;
   localparam int O_CONST = O_FUN + FUN_W;

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_RUN  = RUN;
   localparam logic [1:0] S_DONE = DONE;

   logic [1:0]        state;
   logic [IDX_W-1:0]  step_idx;
   logic [IDX_W-1:0]  last_idx;
   logic [HOLD_W-1:0] hold_cnt;
   logic              loop_q;

   logic [E_W-1:0]    entry;
   logic [HOLD_W-1:0] ent_hold;
   logic [IDX_W:0]    n_clamp;
   logic [IDX_W:0]    n_m1;
   logic              run;
   logic              step_end;

   mux_seq_table #(
      .N_STEPS (N_STEPS),
      .E_W     (E_W)
   ) u_table (
      .clk     (clk),
      .reset   (reset),
      .we      (bus.cfg_we),
      .busy    (run),
      .addr    (bus.cfg_addr),
      .wdata   (bus.cfg_data),
      .rd_idx  (step_idx),
      .rd_data (entry)
   );

   assign ent_hold = entry[O_HOLD +: HOLD_W];
   assign n_clamp  = (bus.num_steps > (IDX_W+1)'(N_STEPS)) ? (IDX_W+1)'(N_STEPS) : bus.num_steps;
   assign n_m1     = n_clamp - (IDX_W+1)'(1);
   assign run      = (state == S_RUN);
   // hold_cnt counts cycles already spent in the step; the step ends when it
   // reaches the live entry's hold, so a write landing with start is honoured.
   assign step_end = (hold_cnt == ent_hold);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         step_idx <= '0;
         last_idx <= '0;
         hold_cnt <= '0;
         loop_q   <= 1'b0;
      end else if (bus.abort) begin
         state    <= S_IDLE;
         step_idx <= '0;
         hold_cnt <= '0;
      end else begin
         case (state)
            S_RUN: begin
               if (!step_end) begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end else begin
                  hold_cnt <= '0;
                  if (step_idx != last_idx) begin
                     step_idx <= step_idx + IDX_W'(1);
                  end else begin
                     step_idx <= '0;
                     if (!loop_q) state <= S_DONE;
                  end
               end
            end
            default: begin
               if (bus.start) begin
                  loop_q   <= bus.loop_en;
                  step_idx <= '0;
                  hold_cnt <= '0;
                  if (n_clamp == '0) begin
                     state <= S_DONE;
                  end else begin
                     state    <= S_RUN;
                     last_idx <= n_m1[IDX_W-1:0];
                  end
               end
            end
         endcase
      end
   end

   // NOTE: every output gets a default at the top of the block so no path
   // through it can leave a value unassigned and infer a latch.
   always_comb begin
      bus.sel_const  = '0;
      bus.sel_fun    = '0;
      bus.sel_acum   = '0;
      bus.senal      = 1'b0;
      bus.ultimo     = 1'b0;
      bus.busy       = run;
      bus.band_listo = (state == S_DONE);
      if (run) begin
         bus.sel_const = entry[O_CONST +: CONST_W];
         bus.sel_fun   = entry[O_FUN +: FUN_W];
         bus.sel_acum  = entry[O_ACUM +: ACUM_W];
         bus.senal     = entry[O_SENAL] && (hold_cnt == '0);
         bus.ultimo    = step_end && (step_idx == last_idx);
      end
   end

endmodule

// File: tb/tb_mux_sequencer.sv
// Self-checking bench for mux_sequencer: vector table plus hand-written corner sequences,
// with expected observations queued on drive and compared one cycle later.
module tb_mux_sequencer;
   import mux_seq_pkg::*;

   typedef struct packed {
      logic [2:0] sc;
      logic [1:0] sf;
      logic [1:0] sa;
      logic       senal;
      logic       busy;
      logic       ultimo;
      logic       listo;
   } obs_t;

   typedef struct {
      logic       start;
      logic       abort;
      logic       loop_en;
      logic [4:0] num_steps;
      obs_t       exp;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   obs_t exp_q[$];
   vec_t vecs[$];

   always #5 clk = ~clk;

   mux_seq_if bus ();

   mux_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic obs_t mk(input int sc, sf, sa, se, b, u, l);
      obs_t o;
      o.sc = 3'(sc); o.sf = 2'(sf); o.sa = 2'(sa);
      o.senal = 1'(se); o.busy = 1'(b); o.ultimo = 1'(u); o.listo = 1'(l);
      return o;
   endfunction

   function automatic vec_t mkv(input logic st, ab, lp, input int n, input obs_t e);
      vec_t v;
      v.start = st; v.abort = ab; v.loop_en = lp; v.num_steps = 5'(n); v.exp = e;
      return v;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o = {bus.sel_const, bus.sel_fun, bus.sel_acum, bus.senal, bus.busy, bus.ultimo, bus.band_listo};
      return o;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick_check(input string name);
      obs_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check({name, "_sb_empty"}, 32'(1), 32'(0));
      end else begin
         e = exp_q.pop_front();
         check(name, 32'(sample()), 32'(e));
      end
   endtask

   task automatic expect_step(input string name, input obs_t e);
      exp_q.push_back(e);
      tick_check(name);
   endtask

   task automatic write_entry(input logic [3:0] addr, input logic [ENTRY_W-1:0] data);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = addr;
      bus.cfg_data = data;
      @(posedge clk);
      #1;
      bus.cfg_we   = 1'b0;
   endtask

   task automatic load_plan_table();
      write_entry(4'd0, pack_entry(3'd1, 2'd3, 2'd0, 1'b0, 4'd0));
      write_entry(4'd1, pack_entry(3'd2, 2'd1, 2'd1, 1'b1, 4'd0));
      write_entry(4'd2, pack_entry(3'd3, 2'd2, 2'd1, 1'b0, 4'd2));
   endtask

   // Steps 1 and 2 of the plan table, then DONE.
   task automatic expect_plan_tail(input string tag);
      expect_step({tag, "_s1"}, mk(2, 1, 1, 1, 1, 0, 0));
      expect_step({tag, "_s2a"}, mk(3, 2, 1, 0, 1, 0, 0));
      expect_step({tag, "_s2b"}, mk(3, 2, 1, 0, 1, 0, 0));
      expect_step({tag, "_s2c"}, mk(3, 2, 1, 0, 1, 1, 0));
      expect_step({tag, "_done"}, mk(0, 0, 0, 0, 0, 0, 1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      obs_t z;
      obs_t e0;
      obs_t e1;
      obs_t e2;
      obs_t e2u;
      z   = mk(0, 0, 0, 0, 0, 0, 0);
      e0  = mk(1, 3, 0, 0, 1, 0, 0);
      e1  = mk(2, 1, 1, 1, 1, 0, 0);
      e2  = mk(3, 2, 1, 0, 1, 0, 0);
      e2u = mk(3, 2, 1, 0, 1, 1, 0);

      // one-shot, n=3
      vecs.push_back(mkv(1, 0, 0, 3, e0));
      vecs.push_back(mkv(0, 0, 0, 3, e1));
      vecs.push_back(mkv(0, 0, 0, 3, e2));
      vecs.push_back(mkv(0, 0, 0, 3, e2));
      vecs.push_back(mkv(0, 0, 0, 3, e2u));
      vecs.push_back(mkv(0, 0, 0, 3, mk(0, 0, 0, 0, 0, 0, 1)));
      vecs.push_back(mkv(0, 0, 0, 3, mk(0, 0, 0, 0, 0, 0, 1)));
      vecs.push_back(mkv(0, 1, 0, 3, z));
      // loop mode, period 5; start in RUN ignored
      vecs.push_back(mkv(1, 0, 1, 3, e0));
      vecs.push_back(mkv(0, 0, 0, 3, e1));
      vecs.push_back(mkv(0, 0, 0, 3, e2));
      vecs.push_back(mkv(0, 0, 0, 3, e2));
      vecs.push_back(mkv(0, 0, 0, 3, e2u));
      vecs.push_back(mkv(0, 0, 0, 3, e0));
      vecs.push_back(mkv(0, 0, 0, 3, e1));
      vecs.push_back(mkv(1, 0, 0, 1, e2));
      vecs.push_back(mkv(0, 0, 0, 3, e2));
      vecs.push_back(mkv(0, 0, 0, 3, e2u));
      vecs.push_back(mkv(0, 0, 0, 3, e0));
      vecs.push_back(mkv(0, 1, 0, 3, z));
      // start+abort together stays IDLE
      vecs.push_back(mkv(1, 1, 0, 3, z));
      // n=0
      vecs.push_back(mkv(1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1)));
      vecs.push_back(mkv(0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1)));
      vecs.push_back(mkv(0, 1, 0, 0, z));

      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.loop_en   = 1'b0;
      bus.num_steps = '0;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_data  = '0;
      #12;
      check("reset_outputs", 32'(sample()), 32'(z));
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("idle_after_reset", 32'(sample()), 32'(z));

      load_plan_table();
      foreach (vecs[i]) begin
         bus.start     = vecs[i].start;
         bus.abort     = vecs[i].abort;
         bus.loop_en   = vecs[i].loop_en;
         bus.num_steps = vecs[i].num_steps;
         expect_step($sformatf("vec%0d", i), vecs[i].exp);
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.loop_en = 1'b0;

      // num_steps beyond the table clamps to N_STEPS
      for (int k = 0; k < 16; k++)
         write_entry(4'(k), pack_entry(3'(k), 2'(k >> 2), 2'(k), 1'(k), 4'd0));
      bus.num_steps = 5'd31;
      bus.start     = 1'b1;
      for (int k = 0; k < 16; k++) begin
         expect_step($sformatf("clamp_step%0d", k),
                     mk(k & 7, (k >> 2) & 3, k & 3, k & 1, 1, (k == 15) ? 1 : 0, 0));
         bus.start = 1'b0;
      end
      expect_step("clamp_done", mk(0, 0, 0, 0, 0, 0, 1));

      // table writes are dropped while busy
      load_plan_table();
      bus.num_steps = 5'd3;
      bus.start     = 1'b1;
      expect_step("bw_run1_s0", e0);
      bus.start    = 1'b0;
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 4'd1;
      bus.cfg_data = pack_entry(3'd7, 2'd0, 2'd0, 1'b0, 4'd0);
      expect_plan_tail("bw_run1");
      bus.cfg_we = 1'b0;
      bus.start  = 1'b1;
      expect_step("bw_run2_s0", e0);
      bus.start = 1'b0;
      expect_plan_tail("bw_run2");

      // write and start in the same cycle: new entry 0 is used
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 4'd0;
      bus.cfg_data = pack_entry(3'd5, 2'd2, 2'd3, 1'b1, 4'd0);
      bus.start    = 1'b1;
      expect_step("wr_start_s0", mk(5, 2, 3, 1, 1, 0, 0));
      bus.cfg_we = 1'b0;
      bus.start  = 1'b0;
      expect_plan_tail("wr_start");
      bus.abort = 1'b1;
      expect_step("abort_from_done", z);
      bus.abort = 1'b0;

      // async reset mid-step 1 clears outputs at once and empties the table
      load_plan_table();
      bus.start = 1'b1;
      expect_step("rst_s0", e0);
      bus.start = 1'b0;
      expect_step("rst_s1", e1);
      #2;
      reset = 1'b1;
      #1;
      check("rst_async_outputs", 32'(sample()), 32'(z));
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      expect_step("rst_zero_s0", mk(0, 0, 0, 0, 1, 0, 0));
      bus.start = 1'b0;
      expect_step("rst_zero_s1", mk(0, 0, 0, 0, 1, 0, 0));
      expect_step("rst_zero_s2", mk(0, 0, 0, 0, 1, 1, 0));
      expect_step("rst_zero_done", mk(0, 0, 0, 0, 0, 0, 1));

      check("sb_drained", 32'(exp_q.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
